// File: rtl/seg_scan_mux_if.sv
// seg_scan_mux_if: display-side bundle for seg_scan_mux.
// The master drives digit data and reads back the scan outputs.
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] digits;
    logic [NUM_DIGITS-1:0]   blank;
    logic [NUM_DIGITS-1:0]   dp;
    logic [3:0]              hex_val;
    logic [NUM_DIGITS-1:0]   an;
    logic                    dp_n;
    logic                    snap_ack;

    modport master (output digits, blank, dp, input hex_val, an, dp_n, snap_ack);
    modport slave  (input digits, blank, dp, output hex_val, an, dp_n, snap_ack);
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: seven-segment digit scanner with per-frame snapshot and anode dead time.
// Defining SEG_LZ_BLANK_EN merges leading zeros into the blank mask at snapshot load.
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int TICK_DIV    = 100000,
    parameter int DEAD_CYCLES = 16
) (
    input logic           clk,
    input logic           reset,
    seg_scan_mux_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [TW-1:0]              tick_cnt;
    logic [IW-1:0]              idx;
    logic [NUM_DIGITS-1:0][3:0] dig_s;
    logic [NUM_DIGITS-1:0]      blank_s;
    logic [NUM_DIGITS-1:0]      dp_s;
    logic [NUM_DIGITS-1:0]      blank_ld;
    logic [NUM_DIGITS-1:0]      lit;
    logic                       load_pend;
    logic                       slot_end;
    logic                       frame_end;
    logic                       load;
    logic                       in_dead;

    assign slot_end  = tick_cnt == TW'(TICK_DIV - 1);
    assign frame_end = slot_end && idx == IW'(NUM_DIGITS - 1);
    assign load      = load_pend || frame_end;

    if (DEAD_CYCLES == 0) begin : g_nodead
        assign in_dead = 1'b0;
    end else begin : g_dead
        assign in_dead = tick_cnt < TW'(DEAD_CYCLES);
    end

`ifdef SEG_LZ_BLANK_EN
    logic zrun;

    // Walk down from the top digit; digit 0 is never leading-blanked.
    always_comb begin
        zrun     = 1'b1;
        blank_ld = bus.blank;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zrun        = zrun && bus.digits[4*i +: 4] == 4'h0;
            blank_ld[i] = bus.blank[i] | zrun;
        end
    end
`else
    assign blank_ld = bus.blank;
`endif

    always_comb begin
        lit      = '0;
        lit[idx] = !in_dead && !blank_s[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_cnt     <= '0;
            idx          <= '0;
            dig_s        <= '0;
            blank_s      <= '1;
            dp_s         <= '0;
            load_pend    <= 1'b1;
            bus.hex_val  <= '0;
            bus.an       <= '1;
            bus.dp_n     <= 1'b1;
            bus.snap_ack <= 1'b0;
        end else begin
            tick_cnt <= slot_end ? '0 : tick_cnt + 1'b1;
            idx      <= frame_end ? '0 : slot_end ? idx + 1'b1 : idx;
            if (load) begin
                dig_s   <= bus.digits;
                blank_s <= blank_ld;
                dp_s    <= bus.dp;
            end
            load_pend    <= 1'b0;
            bus.hex_val  <= dig_s[idx];
            bus.an       <= ~lit;
            bus.dp_n     <= ~(lit[idx] && dp_s[idx]);
            bus.snap_ack <= load;
        end
    end
endmodule

// File: tb/tb_seg_scan_mux.sv
// tb_seg_scan_mux: table, hand-written and random checks of seg_scan_mux against a frame-position model.
// Build with SEG_LZ_BLANK_EN defined to exercise leading-zero blanking.
module tb_seg_scan_mux;
    localparam int ND = 4;
    localparam int TD = 4;
    localparam int DC = 1;
    localparam int FR = ND * TD;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

    seg_scan_mux #(.NUM_DIGITS(ND), .TICK_DIV(TD), .DEAD_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Model: k counts edges since reset release; outputs after edge k reflect scan position k-1.
    int          k;
    logic [15:0] sd;
    logic [3:0]  sb, sp;
    logic [3:0]  e_hex, e_an;
    logic        e_dpn, e_ack;

    function automatic logic [3:0] lz(logic [15:0] d);
        lz = '0;
`ifdef SEG_LZ_BLANK_EN
        for (int i = 3; i > 0; i--) begin
            if (d[4*i +: 4] != 4'h0) break;
            lz[i] = 1'b1;
        end
`endif
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s k=%0d got %h want %h", nm, k, got, exp);
        end
    endtask

    task automatic cyc();
        int  s, tk, id;
        bit  lt;
        @(posedge clk);
        if (reset) begin
            k = 0; sd = '0; sb = '1; sp = '0;
            e_hex = '0; e_an = '1; e_dpn = 1'b1; e_ack = 1'b0;
        end else begin
            s = k;
            k++;
            tk = s % TD;
            id = (s / TD) % ND;
            lt = tk >= DC && !sb[id];
            e_hex = sd[4*id +: 4];
            e_an  = lt ? ~(4'b0001 << id) : 4'hF;
            e_dpn = !(lt && sp[id]);
            e_ack = k == 1 || k % FR == 0;
            if (e_ack) begin
                sd = bus.digits; sb = bus.blank | lz(bus.digits); sp = bus.dp;
            end
        end
        @(negedge clk);
        chk("hex_val", bus.hex_val, e_hex);
        chk("an", bus.an, e_an);
        chk("dp_n", bus.dp_n, e_dpn);
        chk("snap_ack", bus.snap_ack, e_ack);
    endtask

    task automatic run_to(int target);
        while (k < target) cyc();
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  b, p;
        logic [3:0]  lit, lit_lz;
        logic [3:0]  dpl, dpl_lz;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int   acks;
        logic [15:0] hcat;
        logic [3:0]  litm, dpm, xl, xd;
        int   lows, dlows, io;

        tbl[0] = '{16'h1234, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000};
        tbl[1] = '{16'h1234, 4'b1000, 4'b0000, 4'b0111, 4'b0111, 4'b0000, 4'b0000};
        tbl[2] = '{16'h1234, 4'b0000, 4'b0100, 4'b1111, 4'b1111, 4'b0100, 4'b0100};
        tbl[3] = '{16'h0050, 4'b0000, 4'b0000, 4'b1111, 4'b0011, 4'b0000, 4'b0000};
        tbl[4] = '{16'h0000, 4'b0000, 4'b0000, 4'b1111, 4'b0001, 4'b0000, 4'b0000};
        tbl[5] = '{16'h0000, 4'b0001, 4'b1111, 4'b1110, 4'b0000, 4'b1110, 4'b0000};

        k = 0;
        reset = 1'b1; bus.digits = 16'h1234; bus.blank = '0; bus.dp = '0;
        repeat (3) cyc();
        chk("rst_an", bus.an, 4'hF);
        chk("rst_hex", bus.hex_val, 4'h0);
        chk("rst_dpn", bus.dp_n, 1'b1);
        chk("rst_ack", bus.snap_ack, 1'b0);

        reset = 1'b0;
        cyc();
        chk("first_ack", bus.snap_ack, 1'b1);
        chk("first_an", bus.an, 4'hF);
        cyc();
        chk("first_hex", bus.hex_val, 4'h4);
        chk("first_an0", bus.an, 4'b1110);
        cyc();
        chk("first_ack_drop", bus.snap_ack, 1'b0);

        // Tearing: change digits while slot 1 of the second frame is live.
        run_to(21);
        bus.digits = 16'hABCD;
        acks = 0;
        while (k < 32) begin
            cyc();
            acks += int'(bus.snap_ack);
        end
        chk("tear_acks", acks, 1);
        cyc();
        chk("tear_newd0", bus.hex_val, 4'hD);

        // Reset pulse mid slot 2.
        run_to(42);
        reset = 1'b1;
        cyc();
        chk("midrst_an", bus.an, 4'hF);
        chk("midrst_hex", bus.hex_val, 4'h0);
        chk("midrst_dpn", bus.dp_n, 1'b1);
        reset = 1'b0;
        cyc();
        chk("midrst_ack", bus.snap_ack, 1'b1);
        cyc();
        chk("midrst_d0", bus.hex_val, 4'hD);

        foreach (tbl[i]) begin
            reset = 1'b1;
            bus.digits = tbl[i].d; bus.blank = tbl[i].b; bus.dp = tbl[i].p;
            cyc();
            reset = 1'b0;
            run_to(FR);
            hcat = '0; litm = '0; dpm = '0; lows = 0; dlows = 0;
            while (k < 2 * FR) begin
                cyc();
                io = ((k - 1) / TD) % ND;
                hcat[4*io +: 4] = bus.hex_val;
                if (bus.an != 4'hF) begin
                    litm |= ~bus.an;
                    lows++;
                end
                if (!bus.dp_n) begin
                    dpm[io] = 1'b1;
                    dlows++;
                end
            end
`ifdef SEG_LZ_BLANK_EN
            xl = tbl[i].lit_lz; xd = tbl[i].dpl_lz;
`else
            xl = tbl[i].lit; xd = tbl[i].dpl;
`endif
            chk($sformatf("tbl%0d_hex", i), hcat, tbl[i].d);
            chk($sformatf("tbl%0d_lit", i), litm, xl);
            chk($sformatf("tbl%0d_lowcyc", i), lows, 3 * $countones(xl));
            chk($sformatf("tbl%0d_dp", i), dpm, xd);
            chk($sformatf("tbl%0d_dpcyc", i), dlows, 3 * $countones(xd));
        end

        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                for (int j = 0; j < 4; j++)
                    bus.digits[4*j +: 4] = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
                bus.blank = 4'($urandom_range(0, 3) == 0 ? $urandom : 0);
                bus.dp    = 4'($urandom);
            end
            reset = $urandom_range(0, 149) == 0;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
